dp_dtm_dm: RTL and testbench
============================

Name: dp_dtm_dm

Overview:
- RISC-V JTAG Debug Transport Module (DTM) with an integrated minimal Debug Module (DM) register stub.
- The DTM implements the standard 16-state IEEE 1149.1 TAP, a 5-bit IR, and the IDCODE, DTMCS, DMI and BYPASS data registers.
- DMI accesses are issued on an internal DMI bus (address/wdata/op/rdata) to the DM register file. The bus is also exported for observation.
- Sits between the external JTAG pins and the hart debug logic; everything runs in the tck domain.

Parameters:
- IDCODE_VALUE, 32'h1000_0001, value captured by IDCODE DR (bit0 must be 1).
- ABITS, 7, DMI address width.
- DMSTATUS_VALUE, 32'h0000_0082, read-only dmstatus contents (version=2, authenticated=1).

Ports:
- tck  in  1  test clock; the only clock.
- trst  in  1  test reset, asynchronous, active-low.
- tms  in  1  test mode select, sampled on tck rising edge.
- tdi  in  1  test data in, sampled on tck rising edge.
- tdo  out  1  test data out, updated on tck falling edge.
- dmi_address  out  7  DMI bus address.
- dmi_wdata  out  32  DMI bus write data.
- dmi_rdata  out  32  DMI bus read data (driven by the DM).
- dmi_op  out  2  DMI bus op: 0=nop, 1=read, 2=write, 3=reserved (treated as nop).

Behaviour:
- Clocking and reset:
  - One clock (tck); reset (trst) is asynchronous and active-low.
  - While trst=0: TAP=Test-Logic-Reset, IR=IDCODE (5'h01), tdo=0, dmi_address=0, dmi_wdata=0, dmi_op=0, DMI result register=0, DM registers=0.
- TAP:
  - Standard 16 states with the standard tms transitions, evaluated on tck rising edge.
  - tms=1 for 5 consecutive tck reaches Test-Logic-Reset from any state; entering that state also loads IR=IDCODE.
- Instruction register (IR):
  - 5 bits, shifted LSB first.
  - Capture-IR loads 5'b00001.
  - Shift happens on each rising edge while in Shift-IR, including the edge that exits to Exit1-IR.
  - The new IR takes effect on Update-IR.
- IR decode:
  - 5'h00 = BYPASS_0 and 5'h1F = BYPASS: both select the 1-bit bypass register.
  - 5'h01 = IDCODE.
  - 5'h10 = DTMCS.
  - 5'h11 = DMI.
  - Any other IR value selects bypass.
- Data registers: Capture-DR loads the selected register; Shift-DR shifts LSB out, tdi in at the MSB; Update-DR applies the result.
  - BYPASS: capture 0; width 1.
  - IDCODE: capture IDCODE_VALUE; width 32; update has no effect.
  - DTMCS:
    - Width 32; capture 32'h0000_0071 (version=1, abits=7 at [9:4], dmistat=0, idle=0).
    - Update ignored (no busy/error state exists, so dmireset and dmihardreset are no-ops).
  - DMI:
    - Width 41, laid out as [40:34] address, [33:2] data, [1:0] op.
    - Capture loads {last_address, result_data, 2'b00}; status is always 0 (success).
- DMI issue:
  - On the rising edge leaving Update-DR with IR=DMI and op∈{1,2}, latch address→dmi_address, data→dmi_wdata, op→dmi_op.
  - dmi_op is held for exactly one tck cycle, then returns to 0.
  - op 0 or 3: no bus cycle; the address is still latched for the next capture.
- DMI completion:
  - On the tck rising edge where dmi_op≠0, the DTM latches result_data←dmi_rdata (the pre-write value for writes).
  - The DM performs writes on that same edge.
  - Latency is 1 tck; the minimum Update-DR→Capture-DR path is 3 tck, so the response is never busy.
- DM register map:
  - dmi_rdata is combinational from dmi_address.
  - 0x04 data0: RW, 32 bits.
  - 0x05 data1: RW, 32 bits.
  - 0x10 dmcontrol: RW, all 32 bits stored.
  - 0x11 dmstatus: RO, DMSTATUS_VALUE.
  - 0x12 hartinfo: RO, 0.
  - All other addresses read 0; writes to them are ignored.
- tdo:
  - Updated on tck falling edge.
  - Equals the LSB of the active shift register in Shift-IR/Shift-DR; 0 in all other states.
- trst asserted mid-scan aborts any shift or pending dmi_op immediately (async); DM registers are cleared.

Test Plan:
- trst low then high, 1 tck with tms=0, IR←5'h00 (bypass), shift 32 bits with tdi=0 → tdo reads 32'h0000_0000.
- IR←5'h01, Capture-DR, shift 32 bits → tdo LSB-first reads 32'h1000_0001.
- IR←5'h10, shift 32 bits → reads 32'h0000_0071; a subsequent DR write of 32'hFFFF_FFFF is ignored and a re-read still gives 32'h0000_0071.
- IR←5'h11:
  - Write DR 41'h1E1_2345_6789 (addr 0x78, op=1 read) → dmi_op=1 for one tck with dmi_address=0x78.
  - Next 41-bit read returns {7'h78, 32'h0, 2'b00}.
- DMI write addr 0x04, data 32'hDEAD_BEEF, op=2 → one-tck dmi_op=2 with dmi_wdata=32'hDEAD_BEEF.
  - A read op to 0x04 then returns {7'h04, 32'hDEAD_BEEF, 2'b00}.
  - A read of 0x11 returns data 32'h0000_0082.
- Assert trst low in the middle of Shift-DR on DMI → TAP returns to Test-Logic-Reset, IR=IDCODE, dmi_op=0, data0 reads 0 afterwards.

Source files
------------

// File: rtl/dp_dtm_dm.sv
// dp_dtm_dm: RISC-V JTAG DTM (TAP, IR, IDCODE/DTMCS/DMI/BYPASS) with a minimal DM register stub.
module dp_dtm_dm #(
  parameter logic [31:0] IDCODE_VALUE   = 32'h1000_0001,
  parameter int          ABITS          = 7,
  parameter logic [31:0] DMSTATUS_VALUE = 32'h0000_0082
) (
  input  logic             tck,
  input  logic             trst,
  input  logic             tms,
  input  logic             tdi,
  output logic             tdo,
  output logic [ABITS-1:0] dmi_address,
  output logic [31:0]      dmi_wdata,
  output logic [31:0]      dmi_rdata,
  output logic [1:0]       dmi_op
);
  localparam int DW = ABITS + 34;
  localparam logic [3:0] TLR = 4'd0,  RTI = 4'd1,  SDR = 4'd2,  CDR = 4'd3,
                         SHD = 4'd4,  E1D = 4'd5,  PDR = 4'd6,  E2D = 4'd7,
                         UDR = 4'd8,  SIR = 4'd9,  CIR = 4'd10, SHI = 4'd11,
                         E1I = 4'd12, PIR = 4'd13, E2I = 4'd14, UIR = 4'd15;
  localparam logic [4:0] IR_IDCODE = 5'h01, IR_DTMCS = 5'h10, IR_DMI = 5'h11;
  localparam logic [ABITS-1:0] A_DATA0 = ABITS'(4), A_DATA1 = ABITS'(5),
                               A_DMCTL = ABITS'(16), A_DMSTAT = ABITS'(17);
  logic [3:0]       r_state, w_next;
  logic [4:0]       r_ir, r_ir_sh;
  logic [DW-1:0]    r_dr, w_cap, w_shift;
  logic             r_tdo;
  logic [ABITS-1:0] r_addr, r_last_addr;
  logic [31:0]      r_wdata, r_result, r_data0, r_data1, r_dmctl, w_rdata;
  logic [1:0]       r_op;
  logic             w_idc, w_dtmcs, w_dmi, w_bypass, w_issue;
  always_comb begin
    w_next = TLR;
    case (r_state)
      TLR: w_next = tms ? TLR : RTI;
      RTI: w_next = tms ? SDR : RTI;
      SDR: w_next = tms ? SIR : CDR;
      CDR: w_next = tms ? E1D : SHD;
      SHD: w_next = tms ? E1D : SHD;
      E1D: w_next = tms ? UDR : PDR;
      PDR: w_next = tms ? E2D : PDR;
      E2D: w_next = tms ? UDR : SHD;
      UDR: w_next = tms ? SDR : RTI;
      SIR: w_next = tms ? TLR : CIR;
      CIR: w_next = tms ? E1I : SHI;
      SHI: w_next = tms ? E1I : SHI;
      E1I: w_next = tms ? UIR : PIR;
      PIR: w_next = tms ? E2I : PIR;
      E2I: w_next = tms ? UIR : SHI;
      UIR: w_next = tms ? SDR : RTI;
      default: w_next = TLR;
    endcase
  end
  assign w_idc    = r_ir == IR_IDCODE;
  assign w_dtmcs  = r_ir == IR_DTMCS;
  assign w_dmi    = r_ir == IR_DMI;
  assign w_bypass = !(w_idc || w_dtmcs || w_dmi);
  assign w_cap = w_dmi   ? {r_last_addr, r_result, 2'b00} :
                 w_dtmcs ? {{(DW-32){1'b0}}, 22'b0, 6'(ABITS), 4'h1} :
                 w_idc   ? {{(DW-32){1'b0}}, IDCODE_VALUE} : '0;
  // tdi enters at the MSB of whichever register is selected
  assign w_shift = w_dmi    ? {tdi, r_dr[DW-1:1]} :
                   w_bypass ? {{(DW-1){1'b0}}, tdi} :
                              {{(DW-32){1'b0}}, tdi, r_dr[31:1]};
  assign w_issue = r_state == UDR && w_dmi && (r_dr[1:0] == 2'd1 || r_dr[1:0] == 2'd2);
  assign w_rdata = r_addr == A_DATA0  ? r_data0 :
                   r_addr == A_DATA1  ? r_data1 :
                   r_addr == A_DMCTL  ? r_dmctl :
                   r_addr == A_DMSTAT ? DMSTATUS_VALUE : 32'h0;
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      r_state     <= TLR;
      r_ir        <= IR_IDCODE;
      r_ir_sh     <= '0;
      r_dr        <= '0;
      r_op        <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_last_addr <= '0;
      r_result    <= '0;
      r_data0     <= '0;
      r_data1     <= '0;
      r_dmctl     <= '0;
    end else begin
      r_state <= w_next;
      r_ir    <= w_next == TLR ? IR_IDCODE : r_state == UIR ? r_ir_sh : r_ir;
      r_ir_sh <= r_state == CIR ? 5'b00001 : r_state == SHI ? {tdi, r_ir_sh[4:1]} : r_ir_sh;
      r_dr    <= r_state == CDR ? w_cap : r_state == SHD ? w_shift : r_dr;
      r_op    <= w_issue ? r_dr[1:0] : 2'b00;
      if (w_issue) begin
        r_addr  <= r_dr[DW-1:34];
        r_wdata <= r_dr[33:2];
      end
      if (r_state == UDR && w_dmi) r_last_addr <= r_dr[DW-1:34];
      // completion: capture pre-write value while the DM commits the write
      if (r_op != 2'b00) r_result <= w_rdata;
      if (r_op == 2'd2 && r_addr == A_DATA0) r_data0 <= r_wdata;
      if (r_op == 2'd2 && r_addr == A_DATA1) r_data1 <= r_wdata;
      if (r_op == 2'd2 && r_addr == A_DMCTL) r_dmctl <= r_wdata;
    end
  end
  always_ff @(negedge tck or negedge trst) begin
    if (!trst) r_tdo <= 1'b0;
    else r_tdo <= r_state == SHI ? r_ir_sh[0] : r_state == SHD ? r_dr[0] : 1'b0;
  end
  assign tdo         = r_tdo;
  assign dmi_address = r_addr;
  assign dmi_wdata   = r_wdata;
  assign dmi_rdata   = w_rdata;
  assign dmi_op      = r_op;
endmodule

// File: tb/tb_dp_dtm_dm.sv
// tb_dp_dtm_dm: directed JTAG scans against dp_dtm_dm with a queue of expected DR captures.
module tb_dp_dtm_dm;
  logic        tck, trst, tms, tdi, tdo;
  logic [6:0]  dmi_address;
  logic [31:0] dmi_wdata, dmi_rdata;
  logic [1:0]  dmi_op;
  logic        o;
  int          errors = 0, checks = 0;
  logic [40:0] exp_q[$];
  dp_dtm_dm dut (
    .tck(tck), .trst(trst), .tms(tms), .tdi(tdi), .tdo(tdo),
    .dmi_address(dmi_address), .dmi_wdata(dmi_wdata), .dmi_rdata(dmi_rdata), .dmi_op(dmi_op)
  );
  initial tck = 1'b0;
  always #5 tck = ~tck;
  task automatic chk(input string tag, input logic [40:0] obs, input logic [40:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic clk1(input logic m, input logic d, output logic t);
    @(negedge tck);
    #1;
    t = tdo;
    tms = m;
    tdi = d;
    @(posedge tck);
    #1;
  endtask
  task automatic shift_ir(input logic [4:0] v);
    logic t;
    clk1(1, 0, t); clk1(1, 0, t); clk1(0, 0, t); clk1(0, 0, t);
    for (int i = 0; i < 5; i++) clk1(i == 4, v[i], t);
    clk1(1, 0, t); clk1(0, 0, t);
  endtask
  task automatic scan_dr(input int n, input logic [40:0] din, output logic [40:0] dout);
    logic t;
    dout = '0;
    clk1(1, 0, t); clk1(0, 0, t); clk1(0, 0, t);
    for (int i = 0; i < n; i++) begin
      clk1(i == n - 1, din[i], t);
      dout[i] = t;
    end
    clk1(1, 0, t); clk1(0, 0, t);
  endtask
  task automatic dr(input string tag, input int n, input logic [40:0] din, input logic [40:0] exp);
    logic [40:0] dout;
    exp_q.push_back(exp);
    scan_dr(n, din, dout);
    chk(tag, dout, exp_q.pop_front());
  endtask
  initial begin
    trst = 1'b0; tms = 1'b0; tdi = 1'b0;
    repeat (3) @(posedge tck);
    #1;
    chk("rst_tdo", 41'(tdo), 41'd0);
    chk("rst_op", 41'(dmi_op), 41'd0);
    chk("rst_addr", 41'(dmi_address), 41'd0);
    chk("rst_wdata", 41'(dmi_wdata), 41'd0);
    chk("rst_rdata", 41'(dmi_rdata), 41'd0);
    @(negedge tck); #1; trst = 1'b1;
    clk1(0, 0, o);
    dr("idcode_rst", 32, 41'h0, 41'h0_1000_0001);
    shift_ir(5'h00);
    dr("bypass0", 32, 41'h0, 41'h0);
    shift_ir(5'h1F);
    dr("bypass1f", 32, 41'hA5A5_0F0F, 41'h4B4A_1E1E);
    shift_ir(5'h07);
    dr("bypass_other", 8, 41'h96, 41'h2C);
    shift_ir(5'h01);
    dr("idcode", 32, 41'h0, 41'h1000_0001);
    shift_ir(5'h10);
    dr("dtmcs", 32, 41'hFFFF_FFFF, 41'h71);
    dr("dtmcs_again", 32, 41'h0, 41'h71);
    shift_ir(5'h11);
    dr("dmi_rd78", 41, 41'h1E1_2345_6789, 41'h0);
    chk("rd78_op", 41'(dmi_op), 41'd1);
    chk("rd78_addr", 41'(dmi_address), 41'h78);
    clk1(0, 0, o);
    chk("rd78_op_drop", 41'(dmi_op), 41'd0);
    dr("dmi_wr04", 41, {7'h04, 32'hDEAD_BEEF, 2'b10}, {7'h78, 32'h0, 2'b00});
    chk("wr04_op", 41'(dmi_op), 41'd2);
    chk("wr04_addr", 41'(dmi_address), 41'h04);
    chk("wr04_wdata", 41'(dmi_wdata), 41'hDEAD_BEEF);
    clk1(0, 0, o);
    chk("wr04_op_drop", 41'(dmi_op), 41'd0);
    dr("dmi_rd04", 41, {7'h04, 32'h0, 2'b01}, {7'h04, 32'h0, 2'b00});
    dr("dmi_rd11", 41, {7'h11, 32'h0, 2'b01}, {7'h04, 32'hDEAD_BEEF, 2'b00});
    dr("dmi_nop", 41, {7'h05, 32'hFFFF_FFFF, 2'b00}, {7'h11, 32'h82, 2'b00});
    chk("nop_op", 41'(dmi_op), 41'd0);
    dr("dmi_op3", 41, {7'h10, 32'h1, 2'b11}, {7'h05, 32'h82, 2'b00});
    chk("op3_op", 41'(dmi_op), 41'd0);
    dr("dmi_wr10", 41, {7'h10, 32'h1234_5678, 2'b10}, {7'h10, 32'h82, 2'b00});
    dr("dmi_wr05", 41, {7'h05, 32'hCAFE_F00D, 2'b10}, {7'h10, 32'h0, 2'b00});
    dr("dmi_rd10", 41, {7'h10, 32'h0, 2'b01}, {7'h05, 32'h0, 2'b00});
    dr("dmi_rd05", 41, {7'h05, 32'h0, 2'b01}, {7'h10, 32'h1234_5678, 2'b00});
    dr("dmi_wr11", 41, {7'h11, 32'h0, 2'b10}, {7'h05, 32'hCAFE_F00D, 2'b00});
    dr("dmi_rd11b", 41, {7'h11, 32'h0, 2'b01}, {7'h11, 32'h82, 2'b00});
    dr("dmi_rd12", 41, {7'h12, 32'h0, 2'b01}, {7'h11, 32'h82, 2'b00});
    repeat (5) clk1(1, 0, o);
    clk1(0, 0, o);
    dr("tlr_idcode", 32, 41'h0, 41'h1000_0001);
    shift_ir(5'h11);
    clk1(1, 0, o); clk1(0, 0, o); clk1(0, 0, o);
    for (int i = 0; i < 10; i++) clk1(0, 1, o);
    @(negedge tck); #1; trst = 1'b0;
    #1;
    chk("abort_tdo", 41'(tdo), 41'd0);
    chk("abort_op", 41'(dmi_op), 41'd0);
    repeat (2) @(posedge tck);
    @(negedge tck); #1; trst = 1'b1;
    clk1(0, 0, o);
    dr("idcode_after_trst", 32, 41'h0, 41'h1000_0001);
    shift_ir(5'h11);
    dr("rd04_cleared", 41, {7'h04, 32'h0, 2'b01}, 41'h0);
    dr("nop_cleared", 41, 41'h0, {7'h04, 32'h0, 2'b00});
    dr("wr04_pending", 41, {7'h04, 32'h5555_AAAA, 2'b10}, 41'h0);
    chk("pending_op", 41'(dmi_op), 41'd2);
    trst = 1'b0;
    #1;
    chk("pending_abort_op", 41'(dmi_op), 41'd0);
    chk("pending_abort_wdata", 41'(dmi_wdata), 41'd0);
    @(negedge tck); #1; trst = 1'b1;
    clk1(0, 0, o);
    shift_ir(5'h11);
    dr("rd04_after_abort", 41, {7'h04, 32'h0, 2'b01}, 41'h0);
    dr("nop_after_abort", 41, 41'h0, {7'h04, 32'h0, 2'b00});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
